// File: rtl/casl_key_loader_if.sv
// Byte-stream, control and key-bus signals of the CAS-Lock key loader.
// master = software/driver side, slave = the loader itself.
interface casl_key_loader_if #(
  parameter int unsigned KEY_W = 64
);
  logic             s_valid;
  logic [7:0]       s_data;
  logic             s_last;
  logic             s_ready;
  logic             commit;
  logic             clear;
  logic [KEY_W-1:0] key_out;
  logic             key_valid;
  logic             busy;
  logic             pend;
  logic             err;
  logic [1:0]       err_code;

  modport master (
    output s_valid, s_data, s_last, commit, clear,
    input  s_ready, key_out, key_valid, busy, pend, err, err_code
  );

  modport slave (
    input  s_valid, s_data, s_last, commit, clear,
    output s_ready, key_out, key_valid, busy, pend, err, err_code
  );
endinterface

// File: rtl/casl_key_loader.sv
// Loads a KEY_W-bit unlock key as bytes plus an XOR checksum byte, holds it staged until
// commit, then drives it to the locked core. key_out is zero until committed and after errors.
module casl_key_loader #(
  parameter int unsigned KEY_W             = 64,
  parameter bit          LOCK_AFTER_COMMIT = 1'b0
) (
  input logic               clk,
  input logic               rst,
  casl_key_loader_if.slave  bus
);
  localparam int unsigned BEATS = KEY_W / 8;
  localparam int unsigned CNT_W = $clog2(BEATS + 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_PEND  = 3'd2;
  localparam logic [2:0] ST_ARMED = 3'd3;
  localparam logic [2:0] ST_ERROR = 3'd4;

  logic [2:0]       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [KEY_W-1:0] r_staged, w_staged_nxt;
  logic [KEY_W-1:0] r_key, w_key_nxt;
  logic [7:0]       r_xor, w_xor_nxt;
  logic             r_key_valid, w_key_valid_nxt;
  logic [1:0]       r_err_code, w_err_code_nxt;
  logic             r_run;
  logic             w_ready, w_xfer, w_fault;
  logic [1:0]       w_fault_code;

  // r_run keeps s_ready low until the first clock edge after reset is released.
  always_comb begin
    case (r_state)
      ST_IDLE:  w_ready = r_run;
      ST_LOAD:  w_ready = 1'b1;
      ST_ARMED: w_ready = !LOCK_AFTER_COMMIT;
      default:  w_ready = 1'b0;
    endcase
  end

  assign w_xfer = bus.s_valid && w_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_staged_nxt    = r_staged;
    w_key_nxt       = r_key;
    w_xor_nxt       = r_xor;
    w_key_valid_nxt = r_key_valid;
    w_err_code_nxt  = r_err_code;
    w_fault         = 1'b0;
    w_fault_code    = 2'b00;

    if (bus.clear) begin
      w_state_nxt     = ST_IDLE;
      w_cnt_nxt       = '0;
      w_staged_nxt    = '0;
      w_key_nxt       = '0;
      w_xor_nxt       = '0;
      w_key_valid_nxt = 1'b0;
      w_err_code_nxt  = 2'b00;
    end else begin
      case (r_state)
        ST_IDLE, ST_ARMED: begin
          if (w_xfer) begin
            if (bus.s_last) begin
              w_fault      = 1'b1;
              w_fault_code = 2'b10;
            end else begin
              w_staged_nxt[7:0] = bus.s_data;
              w_xor_nxt         = bus.s_data;
              w_cnt_nxt         = CNT_W'(1);
              w_state_nxt       = ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (w_xfer) begin
            if (r_cnt < CNT_W'(BEATS)) begin
              if (bus.s_last) begin
                w_fault      = 1'b1;
                w_fault_code = 2'b10;
              end else begin
                for (int unsigned b = 0; b < BEATS; b++) begin
                  if (r_cnt == CNT_W'(b)) w_staged_nxt[8*b +: 8] = bus.s_data;
                end
                w_xor_nxt = r_xor ^ bus.s_data;
                w_cnt_nxt = r_cnt + CNT_W'(1);
              end
            end else if (!bus.s_last) begin
              w_fault      = 1'b1;
              w_fault_code = 2'b11;
            end else if (bus.s_data != r_xor) begin
              w_fault      = 1'b1;
              w_fault_code = 2'b01;
            end else begin
              w_state_nxt = ST_PEND;
              w_cnt_nxt   = '0;
            end
          end
        end
        ST_PEND: begin
          if (bus.commit) begin
            w_key_nxt       = r_staged;
            w_key_valid_nxt = 1'b1;
            w_staged_nxt    = '0;
            w_state_nxt     = ST_ARMED;
          end
        end
        default: ;
      endcase

      // Any fault also withdraws a previously armed key from the core.
      if (w_fault) begin
        w_state_nxt     = ST_ERROR;
        w_cnt_nxt       = '0;
        w_staged_nxt    = '0;
        w_key_nxt       = '0;
        w_xor_nxt       = '0;
        w_key_valid_nxt = 1'b0;
        w_err_code_nxt  = w_fault_code;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_staged    <= '0;
      r_key       <= '0;
      r_xor       <= '0;
      r_key_valid <= 1'b0;
      r_err_code  <= 2'b00;
      r_run       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_staged    <= w_staged_nxt;
      r_key       <= w_key_nxt;
      r_xor       <= w_xor_nxt;
      r_key_valid <= w_key_valid_nxt;
      r_err_code  <= w_err_code_nxt;
      r_run       <= 1'b1;
    end
  end

  assign bus.s_ready   = w_ready;
  assign bus.key_out   = r_key;
  assign bus.key_valid = r_key_valid;
  assign bus.busy      = (r_state == ST_LOAD);
  assign bus.pend      = (r_state == ST_PEND);
  assign bus.err       = (r_state == ST_ERROR);
  assign bus.err_code  = r_err_code;
endmodule
